// File: rtl/acumulador_soma.sv
// Sequential signed accumulator wrapped around an external combinational ripple adder.
// One operand per IDLE -> CALC -> HOLD pass, with optional saturation and a sticky overflow flag.
module acumulador_soma #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SAT_EN = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dado,
    input  logic             in_load,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] soma_a,
    output logic [WIDTH-1:0] soma_b,
    input  logic [WIDTH-1:0] soma_c,
    input  logic             soma_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dado,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] n_ops
);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             ld_q, ld_d;
    logic [WIDTH-1:0] out_dado_q, out_dado_d;
    logic             out_ovf_q, out_ovf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] n_ops_q, n_ops_d;

    logic             ovf_eff;
    logic [WIDTH-1:0] res;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        op_d         = op_q;
        ld_d         = ld_q;
        out_dado_d   = out_dado_q;
        out_ovf_d    = out_ovf_q;
        ovf_sticky_d = ovf_sticky_q;
        n_ops_d      = n_ops_q;
        soma_a       = '0;
        soma_b       = '0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        // A load passes through the adder as 0 + operand, so it can never overflow.
        ovf_eff = soma_ovf & ~ld_q;
        if (SAT_EN && ovf_eff) begin
            res = op_q[WIDTH-1] ? SatMin : SatMax;
        end else begin
            res = soma_c;
        end

        // Clear first so a coincident CALC overflow still sets the flag.
        if (clr_ovf) begin
            ovf_sticky_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_dado;
                    ld_d    = in_load;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                soma_a       = ld_q ? '0 : acc_q;
                soma_b       = op_q;
                acc_d        = res;
                out_dado_d   = res;
                out_ovf_d    = ovf_eff;
                ovf_sticky_d = ovf_sticky_d | ovf_eff;
                if (n_ops_q != CntMax) begin
                    n_ops_d = n_ops_q + CNT_W'(1);
                end
                state_d = StHold;
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            op_q         <= '0;
            ld_q         <= 1'b0;
            out_dado_q   <= '0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            n_ops_q      <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            op_q         <= op_d;
            ld_q         <= ld_d;
            out_dado_q   <= out_dado_d;
            out_ovf_q    <= out_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            n_ops_q      <= n_ops_d;
        end
    end

    assign out_dado   = out_dado_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign n_ops      = n_ops_q;

endmodule

// File: tb/tb_acumulador_soma.sv
// Bench for acumulador_soma: a saturating/8-bit-counter instance and a wrapping/2-bit-counter
// instance run in lockstep, each with its own behavioural adder and integer reference model.
module tb_acumulador_soma;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [15:0] d;
        logic        ld;
        logic        clr;
        logic        ordy;
        logic        rdy;
        logic        vld;
        logic [15:0] dado0;
        logic [15:0] dado1;
        logic        ovf0;
        logic        ovf1;
        logic        stk0;
        logic        stk1;
        logic [7:0]  n0;
        logic [1:0]  n1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_dado = '0;
    logic        in_load = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_ovf0, ovf_sticky0, soma_ovf0;
    logic [15:0] soma_a0, soma_b0, soma_c0, out_dado0;
    logic [7:0]  n_ops0;
    logic        in_ready1, out_valid1, out_ovf1, ovf_sticky1, soma_ovf1;
    logic [15:0] soma_a1, soma_b1, soma_c1, out_dado1;
    logic [1:0]  n_ops1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the ripple adder: plain sum and signed-overflow detection.
    assign soma_c0   = soma_a0 + soma_b0;
    assign soma_ovf0 = (soma_a0[15] == soma_b0[15]) && (soma_c0[15] != soma_a0[15]);
    assign soma_c1   = soma_a1 + soma_b1;
    assign soma_ovf1 = (soma_a1[15] == soma_b1[15]) && (soma_c1[15] != soma_a1[15]);

    acumulador_soma #(.WIDTH(16), .SAT_EN(1'b1), .CNT_W(8)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_dado(in_dado), .in_load(in_load), .clr_ovf(clr_ovf),
        .soma_a(soma_a0), .soma_b(soma_b0), .soma_c(soma_c0), .soma_ovf(soma_ovf0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_dado(out_dado0),
        .out_ovf(out_ovf0), .ovf_sticky(ovf_sticky0), .n_ops(n_ops0)
    );

    acumulador_soma #(.WIDTH(16), .SAT_EN(1'b0), .CNT_W(2)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_dado(in_dado), .in_load(in_load), .clr_ovf(clr_ovf),
        .soma_a(soma_a1), .soma_b(soma_b1), .soma_c(soma_c1), .soma_ovf(soma_ovf1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_dado(out_dado1),
        .out_ovf(out_ovf1), .ovf_sticky(ovf_sticky1), .n_ops(n_ops1)
    );

    // Reference model: transaction phase (0 waiting, 1 computing, 2 presenting) plus
    // per-instance accumulator, result, flags and count, computed with integer arithmetic.
    int          m_phase = 0;
    logic [15:0] m_op = '0;
    logic        m_ld = 1'b0;
    logic [15:0] m_acc [2];
    logic [15:0] m_out [2];
    logic        m_ovf [2];
    logic        m_stk [2];
    int          m_cnt [2];
    int          cnt_max [2] = '{255, 3};
    bit          sat [2] = '{1'b1, 1'b0};

    task automatic model_step(input vec_t v);
        int s;
        bit ov;
        logic [15:0] r;
        if (!v.rst_n) begin
            m_phase = 0;
            m_op = '0;
            m_ld = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = '0; m_out[k] = '0; m_ovf[k] = 1'b0; m_stk[k] = 1'b0; m_cnt[k] = 0;
            end
        end else begin
            if (v.clr) begin
                m_stk[0] = 1'b0;
                m_stk[1] = 1'b0;
            end
            case (m_phase)
                0: if (v.iv) begin
                    m_op = v.d;
                    m_ld = v.ld;
                    m_phase = 1;
                end
                1: begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_ld) s = int'($signed(m_op));
                        else s = int'($signed(m_acc[k])) + int'($signed(m_op));
                        ov = !m_ld && (s > 32767 || s < -32768);
                        if (ov && sat[k]) r = m_op[15] ? 16'h8000 : 16'h7FFF;
                        else r = s[15:0];
                        m_acc[k] = r;
                        m_out[k] = r;
                        m_ovf[k] = ov;
                        m_stk[k] = m_stk[k] | ov;
                        if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
                    end
                    m_phase = 2;
                end
                default: if (v.ordy) m_phase = 0;
            endcase
        end
    endtask

    function automatic logic [63:0] model_vec(input int k);
        logic [15:0] sa, sb;
        logic [7:0]  cnt;
        sa = (m_phase == 1 && !m_ld) ? m_acc[k] : 16'h0000;
        sb = (m_phase == 1) ? m_op : 16'h0000;
        cnt = 8'(m_cnt[k]);
        return {4'h0, m_phase == 0, m_phase == 2, m_out[k], m_ovf[k], m_stk[k], cnt, sa, sb};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [63:0] a0, a1;
        rst_n = v.rst_n; in_valid = v.iv; in_dado = v.d; in_load = v.ld;
        clr_ovf = v.clr; out_ready = v.ordy;
        model_step(v);
        @(posedge clk);
        #1;
        a0 = {4'h0, in_ready0, out_valid0, out_dado0, out_ovf0, ovf_sticky0, n_ops0,
              soma_a0, soma_b0};
        a1 = {4'h0, in_ready1, out_valid1, out_dado1, out_ovf1, ovf_sticky1, 6'b0, n_ops1,
              soma_a1, soma_b1};
        check("model_sat", a0, model_vec(0));
        check("model_wrap", a1, model_vec(1));
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic [15:0] d,
                                input logic ld, input logic clr, input logic ordy,
                                input logic rdy, input logic vld,
                                input logic [15:0] dado0, input logic [15:0] dado1,
                                input logic ovf0, input logic ovf1,
                                input logic stk0, input logic stk1,
                                input logic [7:0] n0, input logic [1:0] n1);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.d = d; v.ld = ld; v.clr = clr; v.ordy = ordy;
        v.rdy = rdy; v.vld = vld; v.dado0 = dado0; v.dado1 = dado1;
        v.ovf0 = ovf0; v.ovf1 = ovf1; v.stk0 = stk0; v.stk1 = stk1; v.n0 = n0; v.n1 = n1;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        int sel;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst_n = ($urandom_range(0, 63) != 0);
        v.iv = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 7);
        case (sel)
            0: v.d = 16'h7FFF;
            1: v.d = 16'h8000;
            2: v.d = 16'hFFFF;
            3: v.d = 16'h0001;
            default: v.d = 16'($urandom);
        endcase
        v.ld = ($urandom_range(0, 3) == 0);
        v.clr = ($urandom_range(0, 9) == 0);
        v.ordy = ($urandom_range(0, 9) < 7);
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0005, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0005, 16'h0005, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0005, 16'h0005, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 16'h0003, 0, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0008, 16'h0008, 0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0008, 16'h0008, 0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1, 1, 16'h7FFF, 1, 0, 1, 0, 0, 16'h0008, 16'h0008, 0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 3, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 3, 3));
        tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 1, 0, 0, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 3, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h7FFF, 16'h8000, 1, 1, 1, 1, 4, 3));
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 0, 0, 1, 16'h7FFF, 16'h8000, 1, 1, 1, 1, 4, 3));
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 1, 1, 0, 16'h7FFF, 16'h8000, 1, 1, 1, 1, 4, 3));
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 1, 0, 0, 16'h7FFF, 16'h8000, 1, 1, 1, 1, 4, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h7FFE, 16'h7FFF, 0, 1, 0, 1, 5, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h7FFE, 16'h7FFF, 0, 1, 0, 1, 5, 3));
        tbl.push_back(mk(1, 1, 16'h8000, 1, 0, 1, 0, 0, 16'h7FFE, 16'h7FFF, 0, 1, 0, 1, 5, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 0, 1, 6, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 1, 0, 16'h8000, 16'h8000, 0, 0, 0, 0, 6, 3));
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 1, 0, 0, 16'h8000, 16'h8000, 0, 0, 0, 0, 6, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h8000, 16'h7FFF, 1, 1, 1, 1, 7, 3));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h8000, 16'h7FFF, 1, 1, 1, 1, 7, 3));
        tbl.push_back(mk(1, 1, 16'h1234, 1, 0, 1, 0, 0, 16'h8000, 16'h7FFF, 1, 1, 1, 1, 7, 3));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
            check($sformatf("table%0d_sat", i),
                  {in_ready0, out_valid0, out_dado0, out_ovf0, ovf_sticky0, n_ops0},
                  {tbl[i].rdy, tbl[i].vld, tbl[i].dado0, tbl[i].ovf0, tbl[i].stk0, tbl[i].n0});
            check($sformatf("table%0d_wrap", i),
                  {in_ready1, out_valid1, out_dado1, out_ovf1, ovf_sticky1, n_ops1},
                  {tbl[i].rdy, tbl[i].vld, tbl[i].dado1, tbl[i].ovf1, tbl[i].stk1, tbl[i].n1});
        end

        // Backpressure: result must sit still while new operands are offered.
        apply(mk(1, 1, 16'h0100, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            apply(mk(1, 1, 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            check("bp_hold", {in_ready0, out_valid0, out_dado0}, {1'b0, 1'b1, 16'h0100});
        end
        apply(mk(1, 1, 16'h0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("bp_release", {in_ready0, out_valid0}, {1'b1, 1'b0});
        apply(mk(1, 1, 16'h0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("bp_accept", {in_ready0, soma_a0, soma_b0}, {1'b0, 16'h0100, 16'h0001});
        apply(mk(1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("bp_result", {out_valid0, out_dado0}, {1'b1, 16'h0101});

        for (int i = 0; i < 800; i++) begin
            v = rnd_vec();
            apply(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
